// File: rtl/pdm_audio_rx.sv
// PDM audio receiver: synchronizes a 1-bit pulse-density stream, counts ones over
// 2^LOG2_DECIM clocks, scales the count to 16 bits and queues it in a small FWFT FIFO.
module pdm_audio_rx #(
    parameter int unsigned LOG2_DECIM = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        capture,
    input  logic        pdm_in,
    output logic [15:0] sample_out,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic        overflow,
    input  logic        clear_overflow
);

    localparam int unsigned L     = LOG2_DECIM;
    localparam int unsigned ACC_W = L + 1;
    localparam int unsigned SHIFT = 16 - L;
    localparam int unsigned SCL_W = 17;
    localparam int unsigned AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW    = AW + 1;

    logic             meta_q, meta_d;
    logic             bit_s_q, bit_s_d;
    logic [L-1:0]     phase_q, phase_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [15:0]      mem_q [FIFO_DEPTH];
    logic [15:0]      mem_d [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [15:0]      sample_out_q, sample_out_d;
    logic             sample_valid_q, sample_valid_d;
    logic             overflow_q, overflow_d;

    logic [ACC_W-1:0] sum_c;
    logic [SCL_W-1:0] scaled_c;
    logic [15:0]      samp_c;
    logic             last_phase_c;
    logic             win_done_c;
    logic             full_c;
    logic             pop_c;
    logic             push_c;
    logic             drop_c;

    // Next-state: synchronizer, window accumulator, scaling, FIFO and sticky overflow
    always_comb begin
        meta_d         = pdm_in;
        bit_s_d        = meta_q;
        phase_d        = '0;
        acc_d          = '0;
        mem_d          = mem_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        sample_out_d   = '0;
        sample_valid_d = 1'b0;
        overflow_d     = overflow_q;

        sum_c        = acc_q + ACC_W'(bit_s_q);
        last_phase_c = &phase_q;
        win_done_c   = capture && last_phase_c;

        // A full-scale count (2^L) overshoots 16 bits after the shift and saturates.
        scaled_c = SCL_W'(sum_c) << SHIFT;
        samp_c   = scaled_c[16] ? 16'hFFFF : scaled_c[15:0];

        if (capture && !last_phase_c) begin
            phase_d = phase_q + L'(1);
            acc_d   = sum_c;
        end

        full_c = (count_q == CW'(FIFO_DEPTH));
        pop_c  = sample_valid_q && sample_ready;
        push_c = win_done_c && (!full_c || pop_c);
        drop_c = win_done_c && full_c && !pop_c;

        if (push_c) begin
            mem_d[wr_ptr_q] = samp_c;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(push_c) - CW'(pop_c);

        sample_valid_d = (count_d != '0);
        if (sample_valid_d) begin
            sample_out_d = mem_d[rd_ptr_d];
        end

        if (drop_c) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            meta_q         <= 1'b0;
            bit_s_q        <= 1'b0;
            phase_q        <= '0;
            acc_q          <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            sample_out_q   <= '0;
            sample_valid_q <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            meta_q         <= meta_d;
            bit_s_q        <= bit_s_d;
            phase_q        <= phase_d;
            acc_q          <= acc_d;
            mem_q          <= mem_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            sample_out_q   <= sample_out_d;
            sample_valid_q <= sample_valid_d;
            overflow_q     <= overflow_d;
        end
    end

    assign sample_out   = sample_out_q;
    assign sample_valid = sample_valid_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_pdm_audio_rx.sv
// Directed bench for pdm_audio_rx (LOG2_DECIM=8, FIFO_DEPTH=4).
module tb_pdm_audio_rx;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic        capture;
    logic        pdm_in;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        sample_ready;
    logic        overflow;
    logic        clear_overflow;

    always #5 clk_in = ~clk_in;

    pdm_audio_rx #(.LOG2_DECIM(8), .FIFO_DEPTH(4)) dut (
        .clk_in         (clk_in),
        .rst_n          (rst_n),
        .capture        (capture),
        .pdm_in         (pdm_in),
        .sample_out     (sample_out),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int cyc0   = 0;
    int mode   = 0;
    logic        lvl = 1'b0;
    logic [15:0] dac_code = '0;
    logic [15:0] dac_acc  = '0;
    logic [16:0] dac_sum;
    logic [15:0] got_v[$];
    int          got_t[$];

    always @(posedge clk_in) cyc <= cyc + 1;

    // Record every accepted sample with its cycle relative to the window start
    always @(negedge clk_in) begin
        if (rst_n && sample_valid && sample_ready) begin
            got_v.push_back(sample_out);
            got_t.push_back(cyc - cyc0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // r is the cycle in which the bit driven now appears at the synchronizer output
    function automatic logic pdm_val();
        int r;
        r = cyc - cyc0 + 2;
        case (mode)
            0:       return lvl;
            1:       return (r & 1) == 0;
            2:       return (r & 3) == 0;
            3:       return (r >= 0) && ((r % 256) >= 256 - 32 * (r / 256 + 1));
            default: return 1'b0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
        if (mode == 4) begin
            dac_sum = {1'b0, dac_acc} + {1'b0, dac_code};
            dac_acc = dac_sum[15:0];
            pdm_in  = dac_sum[16];
        end else begin
            pdm_in = pdm_val();
        end
    endtask

    task automatic run_to(input int c);
        while (cyc - cyc0 < c) tick();
    endtask

    task automatic prerun();
        capture = 1'b0;
        cyc0    = cyc + 8;
        repeat (8) tick();
        got_v.delete();
        got_t.delete();
    endtask

    task automatic run_stream(input int nwin);
        prerun();
        capture = 1'b1;
        repeat (nwin * 256 + 3) tick();
        capture = 1'b0;
    endtask

    task automatic check_stream(input string tag, input int n, input logic [15:0] first,
                                input logic [15:0] rest, input bit chk_first);
        chk({tag, "_count"}, got_v.size(), n);
        for (int k = 0; k < n && k < got_v.size(); k++) begin
            if (k > 0 || chk_first) begin
                chk({tag, "_val"}, got_v[k], (k == 0) ? first : rest);
                chk({tag, "_time"}, got_t[k], 256 * (k + 1));
            end
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        capture        = 1'b0;
        pdm_in         = 1'b1;
        mode           = 0;
        lvl            = 1'b1;
        sample_ready   = 1'b1;
        clear_overflow = 1'b0;
        repeat (3) tick();
        chk("rst_out", sample_out, 0);
        chk("rst_valid", sample_valid, 0);
        chk("rst_ovf", overflow, 0);

        // Constant 1 straight out of reset: first window sees two stale zeros
        rst_n   = 1'b1;
        capture = 1'b1;
        cyc0    = cyc;
        repeat (255) tick();
        chk("c1_valid_early", sample_valid, 0);
        tick();
        chk("c1_valid_256", sample_valid, 1);
        chk("c1_first", sample_out, 16'hFE00);
        repeat (2 * 256 + 2) tick();
        capture = 1'b0;
        check_stream("c1", 3, 16'hFE00, 16'hFFFF, 1'b1);

        mode = 0; lvl = 1'b0;
        run_stream(3);
        check_stream("c0", 3, 16'h0000, 16'h0000, 1'b1);
        chk("c0_ovf", overflow, 0);

        mode = 1;
        run_stream(3);
        check_stream("p10", 3, 16'h8000, 16'h8000, 1'b1);

        mode = 2;
        run_stream(3);
        check_stream("p1000", 3, 16'h4000, 16'h4000, 1'b1);

        mode = 4; dac_code = 16'h4000;
        run_stream(4);
        check_stream("dac4000", 4, 16'h0000, 16'h4000, 1'b0);

        mode = 4; dac_code = 16'hC000;
        run_stream(4);
        check_stream("dacC000", 4, 16'h0000, 16'hC000, 1'b0);

        // Backpressure: window k holds 32*(k+1) ones at its end
        mode = 3; sample_ready = 1'b0;
        prerun();
        capture = 1'b1;
        run_to(1024);
        chk("bp_ovf_4win", overflow, 0);
        chk("bp_valid_4win", sample_valid, 1);
        run_to(1280);
        chk("bp_ovf_5win", overflow, 1);
        capture      = 1'b0;
        sample_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("bp_pop", sample_out, 32'h2000 * (k + 1));
            tick();
        end
        chk("bp_empty_valid", sample_valid, 0);
        chk("bp_empty_out", sample_out, 0);
        chk("bp_ovf_sticky", overflow, 1);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        chk("bp_clear", overflow, 0);

        // Full with simultaneous pop accepts the push; later a drop beats a clear
        sample_ready = 1'b0;
        prerun();
        capture = 1'b1;
        run_to(1279);
        sample_ready = 1'b1;
        tick();
        sample_ready = 1'b0;
        chk("full_pop_ovf", overflow, 0);
        chk("full_pop_head", sample_out, 16'h4000);
        run_to(1535);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        chk("clr_vs_drop", overflow, 1);
        capture      = 1'b0;
        sample_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("full_pop_order", sample_out, 32'h2000 * (k + 2));
            tick();
        end
        chk("full_pop_empty", sample_valid, 0);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;

        // Abort at phase 100, re-enable 10 cycles later
        mode = 0; lvl = 1'b1; sample_ready = 1'b0;
        prerun();
        capture = 1'b1;
        run_to(100);
        capture = 1'b0;
        run_to(110);
        capture = 1'b1;
        run_to(365);
        chk("abort_no_sample", sample_valid, 0);
        tick();
        chk("abort_valid", sample_valid, 1);
        chk("abort_val", sample_out, 16'hFFFF);

        // Asynchronous reset mid-window
        run_to(400);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", sample_valid, 0);
        chk("arst_out", sample_out, 0);
        chk("arst_ovf", overflow, 0);
        capture = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("arst_after_valid", sample_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
